seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream display stage for the stopwatch's four BCD digits (Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds).
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display with active-low anodes, segments and decimal point.
- Snapshots all four digits at each frame boundary so a frame never mixes old and new values.
- Inserts anode dead time between digit slots to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000, clocks per digit slot; legal range >= 2.
- DEAD_CYCLES, 500, clocks at the start of each slot with all anodes off; legal range 0 <= DEAD_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all registers use the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Minutes  input  4  BCD minutes digit.
- Tens_Seconds  input  4  BCD tens-of-seconds digit.
- Ones_Seconds  input  4  BCD ones-of-seconds digit.
- Tenths_Seconds  input  4  BCD tenths digit.
- blank  input  1  1 = force all anodes off; counters keep running.
- an  output  4  anode enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-clock pulse at each snapshot load.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-frame):
  - an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
  - Prescaler cnt=0, digit index idx=0, snapshot registers=0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- idx (2 bits) advances 0->1->2->3->0 on the edge where cnt==REFRESH_DIV-1.
- Frame boundary is the edge where cnt==REFRESH_DIV-1 and idx==3. On that edge:
  - All four input digits are sampled into the snapshot in the same edge as idx->0.
  - frame_tick=1 for exactly that following cycle.
- Inputs are ignored between frame boundaries. The first snapshot load occurs 4*REFRESH_DIV clocks after reset release; until then the display shows the reset snapshot (0, 0, 0, 0).
- Slot mapping:
  - idx0 -> an[0], Tenths, dp off.
  - idx1 -> an[1], Ones, dp on.
  - idx2 -> an[2], Tens, dp off.
  - idx3 -> an[3], Minutes, dp on.
  - Display reads M.SS.t.
- Outputs are registered. an, seg and dp reflect the cnt/idx/blank values of the previous cycle (1-clock latency).
- Dead time: while cnt < DEAD_CYCLES, an=4'b1111, seg=7'h7F, dp=1. Otherwise exactly one an bit is low.
- blank=1 forces an=4'b1111, seg=7'h7F, dp=1 one cycle later, and has priority over every other rule. Prescaler, idx and snapshot logic are unaffected.
- Segment encoding (hex {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any non-BCD value 10..15 = 3F (dash, g segment only).
- Simultaneous events:
  - Input digits changing on the frame-boundary edge: the value present before that edge is captured.
  - reset overrides everything.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when snapshot Minutes==0, the idx3 slot keeps an[3]=1, seg=7'h7F, dp=1 (display shows SS.t). All other slots and timing are unchanged.
- Undefined: the Minutes digit is always driven, so 0 shows as "0." on an[3].

Test Plan:
All scenarios use REFRESH_DIV=4 and DEAD_CYCLES=1.
- Reset release with inputs 1,2,3,4 -> an=1111 for 1 cycle per slot, then the slot pattern starting an=1110, seg=40 (snapshot 0). frame_tick pulses at clock 16; the following frame shows an[0] seg=19, an[1] seg=30 dp=0, an[2] seg=24, an[3] seg=79 dp=0.
- Inputs change from 9,5,9,9 to 0,0,0,0 mid-frame -> current frame still shows 9.59.9; the next frame shows 0.00.0; no mixed frame appears.
- Tenths_Seconds=4'hC -> an[0] slot shows seg=3F.
- blank asserted for 10 clocks mid-frame -> an=1111 from the next cycle for the whole interval; digit phase after release matches an unblanked reference count.
- reset driven low mid-slot (asynchronous, between clock edges) -> an=1111, seg=7F, dp=1 immediately. After release, the scan restarts at idx0 with snapshot 0.
- SEG7_LEADING_ZERO_BLANK_EN defined, Minutes=0 -> an[3] never low. With Minutes=3 -> an[3] slot seg=30, dp=0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed common-anode seven-segment scan driver
//
// Purpose:
//   Scans four BCD digits (M.SS.t) onto a 4-digit common-anode display.
//   Digits are snapshotted at each frame boundary so one frame never mixes
//   old and new values. Each digit slot starts with a dead-time window in
//   which all anodes are off, to suppress ghosting.
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, a snapshot Minutes value of 0 leaves the idx3 slot dark.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-low reset
//   Minutes        - BCD minutes digit (an[3], dp on)
//   Tens_Seconds   - BCD tens-of-seconds digit (an[2])
//   Ones_Seconds   - BCD ones-of-seconds digit (an[1], dp on)
//   Tenths_Seconds - BCD tenths digit (an[0])
//   blank          - 1 forces the display dark; scan timing keeps running
//   an             - anode enables, active-low, an[0] rightmost
//   seg            - segments {g,f,e,d,c,b,a}, active-low
//   dp             - decimal point, active-low
//   frame_tick     - one-clock pulse on each snapshot load

module seg7_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Minutes,
   input  logic [3:0] Tens_Seconds,
   input  logic [3:0] Ones_Seconds,
   input  logic [3:0] Tenths_Seconds,
   input  logic       blank,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]  CNT_DEAD = CW'(DEAD_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    snap_min;
   logic [3:0]    snap_tens;
   logic [3:0]    snap_ones;
   logic [3:0]    snap_tenths;

   logic          slot_last;
   logic          frame_end;
   logic          slot_on;
   logic [3:0]    digit;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;   // non-BCD shows a dash
      endcase
      return s;
   endfunction

   assign slot_last = (cnt == CNT_LAST);
   assign frame_end = slot_last && (idx == 2'd3);

   // Prescaler, digit index and snapshot. The snapshot loads on the same
   // edge that idx wraps to 0, so the new frame starts with fresh digits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         idx         <= 2'd0;
         snap_min    <= 4'd0;
         snap_tens   <= 4'd0;
         snap_ones   <= 4'd0;
         snap_tenths <= 4'd0;
         frame_tick  <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (slot_last) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_end) begin
            snap_min    <= Minutes;
            snap_tens   <= Tens_Seconds;
            snap_ones   <= Ones_Seconds;
            snap_tenths <= Tenths_Seconds;
         end
      end
   end

   always_comb begin
      digit   = 4'd0;
      an_nxt  = 4'b1111;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;

      case (idx)
         2'd0:    digit = snap_tenths;
         2'd1:    digit = snap_ones;
         2'd2:    digit = snap_tens;
         default: digit = snap_min;
      endcase

      slot_on = !blank && (cnt >= CNT_DEAD);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if ((idx == 2'd3) && (snap_min == 4'd0)) begin
         slot_on = 1'b0;
      end
`endif

      if (slot_on) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = seg_decode(digit);
         dp_nxt  = ~idx[0];   // dp lit after Ones and Minutes: M.SS.t
      end
   end

   // Registered outputs: one clock behind cnt/idx/blank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule
